// File: rtl/boot_load_ctrl.sv
// boot_load_ctrl: bootloader sequencer that drains the boot UART byte queue.
// Reads a 2-byte little-endian word count, packs every 4 data bytes into a
// little-endian 32-bit word and writes it to instruction memory over a
// ready/valid port. It reports completion or failure to the boot logic.
// Optional feature macro: BOOT_CHECKSUM_EN adds a trailing XOR checksum byte.
// The byte is checked in a CHK state after the last word has been written.
module boot_load_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  q_empty,
  input  logic [7:0]            q_data,
  output logic                  q_remove,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           word_count
);

  localparam logic [ADDR_WIDTH-1:0] LP_BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [31:0]           LP_MAX  = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_WRITE,
`ifdef BOOT_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t                r_state;
  logic [15:0]           r_len;
  logic [1:0]            r_byte_idx;
  logic [23:0]           r_wdata;      // bytes 0..2 of the word; byte 3 goes straight to the output
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_mem_we;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [15:0]           r_word_count;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic [15:0] w_hdr_len;
  logic [15:0] w_wc_next;
  logic        w_consume;

  // Full header length as seen while the high byte is at the queue head
  assign w_hdr_len = {q_data, r_len[7:0]};
  assign w_wc_next = r_word_count + 16'd1;

  // Only the byte-consuming states may pop, and never from an empty queue
  assign w_consume = (r_state == S_HDR_LO) || (r_state == S_HDR_HI) || (r_state == S_DATA)
`ifdef BOOT_CHECKSUM_EN
                     || (r_state == S_CHK)
`endif
                     ;
  assign q_remove = w_consume && !q_empty;

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign word_count = r_word_count;

  // Load sequencer: state, datapath registers and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_byte_idx   <= '0;
      r_wdata      <= '0;
      r_addr       <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_word_count <= '0;
`ifdef BOOT_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_HDR_LO;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_word_count <= '0;
            r_addr       <= LP_BASE;
            r_byte_idx   <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_csum       <= '0;
`endif
          end
        end

        S_HDR_LO: begin
          if (!q_empty) begin
            r_len[7:0] <= q_data;
            r_state    <= S_HDR_HI;
          end
        end

        S_HDR_HI: begin
          if (!q_empty) begin
            r_len[15:8] <= q_data;
            if ({16'd0, w_hdr_len} > LP_MAX) begin
              r_state <= S_ERR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else if (w_hdr_len == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`endif
            end else begin
              r_state    <= S_DATA;
              r_byte_idx <= '0;
            end
          end
        end

        S_DATA: begin
          if (!q_empty) begin
`ifdef BOOT_CHECKSUM_EN
            r_csum <= r_csum ^ q_data;
`endif
            case (r_byte_idx)
              2'd0: r_wdata[7:0]   <= q_data;
              2'd1: r_wdata[15:8]  <= q_data;
              2'd2: r_wdata[23:16] <= q_data;
              default: begin
                // Fourth byte: the word is complete, present it for writing
                r_mem_wdata <= {q_data, r_wdata};
                r_mem_addr  <= r_addr;
                r_mem_we    <= 1'b1;
                r_state     <= S_WRITE;
              end
            endcase
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end

        S_WRITE: begin
          if (mem_ready) begin
            r_mem_we     <= 1'b0;
            r_word_count <= w_wc_next;
            r_addr       <= r_addr + ADDR_WIDTH'(1);
            if (w_wc_next == r_len) begin
`ifdef BOOT_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`endif
            end else begin
              r_state <= S_DATA;
            end
          end
        end

`ifdef BOOT_CHECKSUM_EN
        S_CHK: begin
          if (!q_empty) begin
            r_busy <= 1'b0;
            if (q_data == r_csum) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif

        S_ERR: begin
          // Sticky until reset; start is deliberately ignored here
          r_state <= S_ERR;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Directed testbench for boot_load_ctrl (default build, checksum disabled).
module tb_boot_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        q_empty;
  logic [7:0]  q_data;
  logic        q_remove;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] word_count;

  int checks   = 0;
  int failures = 0;

  // Byte queue model
  logic [7:0] qmem [64];
  int         rd = 0;
  int         wr = 0;
  logic       starve;

  // Monitor counters
  int          n_pops         = 0;
  int          n_writes       = 0;
  int          n_bad_pop      = 0;
  int          n_pop_in_write = 0;
  logic [15:0] wa [32];
  logic [31:0] wd [32];

  always #5 clk = ~clk;

  assign q_empty = (rd == wr) || starve;
  assign q_data  = qmem[rd[5:0]];

  boot_load_ctrl #(
    .ADDR_WIDTH(16),
    .BASE_ADDR (0),
    .MAX_WORDS (4096)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .q_empty   (q_empty),
    .q_data    (q_data),
    .q_remove  (q_remove),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .word_count(word_count)
  );

  // Queue pop handling and memory write capture
  always @(posedge clk) begin
    if (q_remove) begin
      if (q_empty) n_bad_pop <= n_bad_pop + 1;
      else begin
        rd     <= rd + 1;
        n_pops <= n_pops + 1;
      end
      if (mem_we) n_pop_in_write <= n_pop_in_write + 1;
    end
    if (mem_we && mem_ready && !rst) begin
      wa[n_writes[4:0]] <= mem_addr;
      wd[n_writes[4:0]] <= mem_wdata;
      n_writes          <= n_writes + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    qmem[wr[5:0]] = b;
    wr = wr + 1;
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    int n;
    n = 0;
    while (!(done || err) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(done || err)) begin
      failures++;
      $display("FAIL %s_timeout got done=%b err=%b want done|err=1", nm, done, err);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, err, mem_we, q_remove} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b want=00000", {busy, done, err, mem_we, q_remove});
    end
    checks++;
    if (word_count !== 16'd0 || mem_addr !== 16'd0 || mem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got wc=%h addr=%h data=%h want 0", word_count, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, err, mem_we, q_remove} !== 5'b0) begin
      failures++;
      $display("FAIL idle_ctl got=%b want=00000", {busy, done, err, mem_we, q_remove});
    end
  endtask

  task automatic test_basic;
    int p0, w0, w1;
    logic [7:0] b [10];
    b = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    p0 = n_pops;
    w0 = n_writes;
    w1 = w0 + 1;
    for (int i = 0; i < 10; i++) push(b[i]);
    pulse_start;
    wait_end("basic");
    checks++;
    if (n_writes - w0 !== 2) begin
      failures++;
      $display("FAIL basic_nwrites got=%0d want=2", n_writes - w0);
    end
    checks++;
    if (wa[w0[4:0]] !== 16'd0 || wd[w0[4:0]] !== 32'h44332211) begin
      failures++;
      $display("FAIL basic_word0 got addr=%h data=%h want 0000/44332211", wa[w0[4:0]], wd[w0[4:0]]);
    end
    checks++;
    if (wa[w1[4:0]] !== 16'd1 || wd[w1[4:0]] !== 32'h88776655) begin
      failures++;
      $display("FAIL basic_word1 got addr=%h data=%h want 0001/88776655", wa[w1[4:0]], wd[w1[4:0]]);
    end
    checks++;
    if ({busy, done, err} !== 3'b010 || word_count !== 16'd2) begin
      failures++;
      $display("FAIL basic_status got bde=%b wc=%0d want 010 wc=2", {busy, done, err}, word_count);
    end
    checks++;
    if (n_pops - p0 !== 10) begin
      failures++;
      $display("FAIL basic_pops got=%0d want=10", n_pops - p0);
    end
  endtask

  task automatic test_back_to_back;
    int w0;
    w0 = n_writes;
    push(8'h01); push(8'h00); push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    pulse_start;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_flags got done=%b busy=%b want 0/1", done, busy);
    end
    wait_end("restart");
    checks++;
    if (n_writes - w0 !== 1 || wa[w0[4:0]] !== 16'd0 || wd[w0[4:0]] !== 32'hDDCCBBAA) begin
      failures++;
      $display("FAIL restart_write got n=%0d addr=%h data=%h want 1/0000/ddccbbaa",
               n_writes - w0, wa[w0[4:0]], wd[w0[4:0]]);
    end
    checks++;
    if (done !== 1'b1 || word_count !== 16'd1) begin
      failures++;
      $display("FAIL restart_status got done=%b wc=%0d want 1/1", done, word_count);
    end
  endtask

  task automatic test_backpressure;
    int w0, p0, n, cyc;
    w0 = n_writes;
    p0 = n_pops;
    mem_ready = 1'b0;
    push(8'h01); push(8'h00); push(8'hDE); push(8'hAD); push(8'hBE); push(8'hEF);
    pulse_start;
    n = 0;
    while (!mem_we && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!mem_we) begin
      failures++;
      $display("FAIL bp_we_timeout got mem_we=%b want 1", mem_we);
    end
    cyc = 1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 16'd0 || mem_wdata !== 32'hEFBEADDE || q_remove !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d got we=%b addr=%h data=%h rm=%b want 1/0000/efbeadde/0",
                 i, mem_we, mem_addr, mem_wdata, q_remove);
      end
      @(negedge clk);
      if (mem_we) cyc++;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (cyc !== 6 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL bp_we_cycles got=%0d we_after=%b want 6/0", cyc, mem_we);
    end
    checks++;
    if (n_writes - w0 !== 1 || wd[w0[4:0]] !== 32'hEFBEADDE || n_pop_in_write !== 0) begin
      failures++;
      $display("FAIL bp_write got n=%0d data=%h pops_in_write=%0d want 1/efbeadde/0",
               n_writes - w0, wd[w0[4:0]], n_pop_in_write);
    end
    checks++;
    if (done !== 1'b1 || n_pops - p0 !== 6) begin
      failures++;
      $display("FAIL bp_done got done=%b pops=%0d want 1/6", done, n_pops - p0);
    end
  endtask

  task automatic test_starved;
    int w0, n;
    w0 = n_writes;
    push(8'h01); push(8'h00); push(8'h12); push(8'h34); push(8'h56); push(8'h78);
    pulse_start;
    n = 0;
    while (!done && n < 80) begin
      @(negedge clk);
      starve = ~starve;
      n++;
    end
    starve = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL starve_timeout got done=%b want 1", done);
    end
    checks++;
    if (n_bad_pop !== 0) begin
      failures++;
      $display("FAIL starve_pop_empty got=%0d want=0", n_bad_pop);
    end
    checks++;
    if (n_writes - w0 !== 1 || wd[w0[4:0]] !== 32'h78563412) begin
      failures++;
      $display("FAIL starve_word got n=%0d data=%h want 1/78563412", n_writes - w0, wd[w0[4:0]]);
    end
  endtask

  task automatic test_len0;
    int w0, p0;
    w0 = n_writes;
    p0 = n_pops;
    push(8'h00); push(8'h00);
    pulse_start;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL len0_hdr got done=%b busy=%b want 0/1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || word_count !== 16'd0) begin
      failures++;
      $display("FAIL len0_done got done=%b busy=%b wc=%0d want 1/0/0", done, busy, word_count);
    end
    checks++;
    if (n_writes - w0 !== 0 || n_pops - p0 !== 2) begin
      failures++;
      $display("FAIL len0_traffic got writes=%0d pops=%0d want 0/2", n_writes - w0, n_pops - p0);
    end
  endtask

  task automatic test_overflow;
    int w0, p1;
    w0 = n_writes;
    push(8'h01); push(8'h10);
    pulse_start;
    wait_end("ovf");
    checks++;
    if ({busy, done, err} !== 3'b001 || n_writes - w0 !== 0) begin
      failures++;
      $display("FAIL ovf_err got bde=%b writes=%0d want 001/0", {busy, done, err}, n_writes - w0);
    end
    p1 = n_pops;
    push(8'h02); push(8'h00);
    pulse_start;
    repeat (5) @(negedge clk);
    checks++;
    if ({busy, done, err} !== 3'b001 || n_pops - p1 !== 0 || n_writes - w0 !== 0) begin
      failures++;
      $display("FAIL ovf_sticky got bde=%b pops=%0d writes=%0d want 001/0/0",
               {busy, done, err}, n_pops - p1, n_writes - w0);
    end
  endtask

  task automatic test_reset_mid;
    int w0, w2, n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    wr = rd;
    rst = 1'b0;
    @(negedge clk);
    w0 = n_writes;
    mem_ready = 1'b1;
    push(8'h02); push(8'h00);
    for (int i = 1; i <= 8; i++) push(8'(i * 17));
    pulse_start;
    n = 0;
    while (n_writes != w0 + 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    mem_ready = 1'b0;
    n = 0;
    while (!mem_we && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'd1 || mem_wdata !== 32'h88776655) begin
      failures++;
      $display("FAIL mid_second_write got we=%b addr=%h data=%h want 1/0001/88776655",
               mem_we, mem_addr, mem_wdata);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, err, mem_we, q_remove} !== 5'b0 || word_count !== 16'd0 ||
        mem_addr !== 16'd0 || mem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset got ctl=%b wc=%0d addr=%h data=%h want 00000/0/0/0",
               {busy, done, err, mem_we, q_remove}, word_count, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    mem_ready = 1'b1;
    wr = rd;
    push(8'h01); push(8'h00); push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    w2 = w0 + 1;
    pulse_start;
    wait_end("mid_fresh");
    checks++;
    if (n_writes - w0 !== 2 || wa[w2[4:0]] !== 16'd0 || wd[w2[4:0]] !== 32'h44332211) begin
      failures++;
      $display("FAIL mid_fresh_write got n=%0d addr=%h data=%h want 2/0000/44332211",
               n_writes - w0, wa[w2[4:0]], wd[w2[4:0]]);
    end
    checks++;
    if (done !== 1'b1 || word_count !== 16'd1) begin
      failures++;
      $display("FAIL mid_fresh_status got done=%b wc=%0d want 1/1", done, word_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mem_ready = 1'b1;
    starve    = 1'b0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_backpressure;
    test_starved;
    test_len0;
    test_overflow;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
